// File: rtl/mem_req_pkg.sv
// Shared types for the data-RAM request controller: FSM states, access size
// codes and the alignment rule used when MEM_ALIGN_CHECK_EN is defined.
package mem_req_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    // A half must sit on an even address; a word (code 10 or 11) on a multiple of four.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
        logic bad_s;
        case (size)
            SZ_BYTE: bad_s = 1'b0;
            SZ_HALF: bad_s = addr_lo[0];
            default: bad_s = (addr_lo != 2'b00);
        endcase
        return bad_s;
    endfunction

endpackage

// File: rtl/mem_lane_unit.sv
// Little-endian lane logic: extracts and extends a load result from a RAM word,
// and merges a sub-word store into a RAM word for read-modify-write.
module mem_lane_unit
    import mem_req_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  addr_lo,
    input  logic [1:0]  size,
    input  logic        sign_ext,
    input  logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] merge_data
);

    logic [7:0]  byte_s;
    logic [15:0] half_s;

    // Lane selection from the word.
    always_comb begin
        byte_s = 8'h00;
        case (addr_lo)
            2'b00:   byte_s = word[7:0];
            2'b01:   byte_s = word[15:8];
            2'b10:   byte_s = word[23:16];
            2'b11:   byte_s = word[31:24];
            default: byte_s = 8'h00;
        endcase
        if (addr_lo[1]) begin
            half_s = word[31:16];
        end else begin
            half_s = word[15:0];
        end
    end

    // Load result: selected lane widened by sign or zero fill.
    always_comb begin
        load_data = 32'h0000_0000;
        case (size)
            SZ_BYTE: load_data = {{24{sign_ext & byte_s[7]}}, byte_s};
            SZ_HALF: load_data = {{16{sign_ext & half_s[15]}}, half_s};
            default: load_data = word;
        endcase
    end

    // Store merge: only the addressed lane changes, the rest is passed through.
    always_comb begin
        merge_data = word;
        case (size)
            SZ_BYTE: begin
                case (addr_lo)
                    2'b00:   merge_data[7:0]   = wdata[7:0];
                    2'b01:   merge_data[15:8]  = wdata[7:0];
                    2'b10:   merge_data[23:16] = wdata[7:0];
                    2'b11:   merge_data[31:24] = wdata[7:0];
                    default: merge_data = word;
                endcase
            end
            SZ_HALF: begin
                if (addr_lo[1]) begin
                    merge_data[31:16] = wdata[15:0];
                end else begin
                    merge_data[15:0] = wdata[15:0];
                end
            end
            default: merge_data = wdata;
        endcase
    end

endmodule

// File: rtl/mem_req_ctrl.sv
// Data-RAM initiator for the multicycle core: one load/store at a time, with
// read-modify-write for sub-word stores. MEM_ALIGN_CHECK_EN enables misalignment trapping.
module mem_req_ctrl
    import mem_req_pkg::*;
#(
    parameter int RD_LAT = 1,
    parameter int AW     = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req,
    input  logic          we,
    input  logic [1:0]    size,
    input  logic          sign_ext,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic          ack,
    output logic [31:0]   rdata,
    output logic          busy,
    output logic          addr_err,
    output logic [AW-1:0] Addr,
    output logic          R,
    output logic          W,
    output logic [31:0]   W_data,
    input  logic [31:0]   R_data
);

    localparam logic [2:0] CNT_INIT = 3'(RD_LAT - 1);

    state_t        state_r;
    logic [2:0]    cnt_r;
    logic          we_r;
    logic [1:0]    size_r;
    logic          sign_ext_r;
    logic [1:0]    addr_lo_r;
    logic [31:0]   wdata_r;
    logic          ack_r;
    logic          busy_r;
    logic          rd_r;
    logic          wr_r;
    logic [AW-1:0] ram_addr_r;
    logic [31:0]   ram_wdata_r;
    logic [31:0]   rdata_r;
    logic [31:0]   load_data_s;
    logic [31:0]   merge_data_s;

    // The lane unit works on R_data directly so the result is registered on the capture edge.
    mem_lane_unit u_lane (
        .word       (R_data),
        .addr_lo    (addr_lo_r),
        .size       (size_r),
        .sign_ext   (sign_ext_r),
        .wdata      (wdata_r),
        .load_data  (load_data_s),
        .merge_data (merge_data_s)
    );

`ifdef MEM_ALIGN_CHECK_EN
    logic addr_err_r;
    assign addr_err = addr_err_r;
`else
    assign addr_err = 1'b0;
`endif

    // Request sequencing: capture the request, strobe the RAM, report completion.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= IDLE;
            cnt_r       <= 3'd0;
            we_r        <= 1'b0;
            size_r      <= SZ_BYTE;
            sign_ext_r  <= 1'b0;
            addr_lo_r   <= 2'b00;
            wdata_r     <= 32'h0000_0000;
            ack_r       <= 1'b0;
            busy_r      <= 1'b0;
            rd_r        <= 1'b0;
            wr_r        <= 1'b0;
            ram_addr_r  <= {AW{1'b0}};
            ram_wdata_r <= 32'h0000_0000;
            rdata_r     <= 32'h0000_0000;
`ifdef MEM_ALIGN_CHECK_EN
            addr_err_r  <= 1'b0;
`endif
        end else begin
            case (state_r)
                IDLE: begin
                    if (req) begin
                        we_r       <= we;
                        size_r     <= size;
                        sign_ext_r <= sign_ext;
                        addr_lo_r  <= addr[1:0];
                        wdata_r    <= wdata;
                        ram_addr_r <= {addr[AW-1:2], 2'b00};
`ifdef MEM_ALIGN_CHECK_EN
                        if (is_misaligned(size, addr[1:0])) begin
                            state_r    <= DONE;
                            ack_r      <= 1'b1;
                            addr_err_r <= 1'b1;
                        end else
`endif
                        if (we && size[1]) begin
                            state_r     <= WR;
                            wr_r        <= 1'b1;
                            ram_wdata_r <= wdata;
                            busy_r      <= 1'b1;
                        end else begin
                            state_r <= RD;
                            rd_r    <= 1'b1;
                            cnt_r   <= CNT_INIT;
                            busy_r  <= 1'b1;
                        end
                    end
                end
                RD: begin
                    if (cnt_r == 3'd0) begin
                        rd_r <= 1'b0;
                        if (we_r) begin
                            state_r     <= WR;
                            wr_r        <= 1'b1;
                            ram_wdata_r <= merge_data_s;
                        end else begin
                            state_r <= DONE;
                            ack_r   <= 1'b1;
                            busy_r  <= 1'b0;
                            rdata_r <= load_data_s;
                        end
                    end else begin
                        cnt_r <= cnt_r - 3'd1;
                    end
                end
                WR: begin
                    wr_r    <= 1'b0;
                    state_r <= DONE;
                    ack_r   <= 1'b1;
                    busy_r  <= 1'b0;
                end
                DONE: begin
                    ack_r   <= 1'b0;
                    state_r <= IDLE;
`ifdef MEM_ALIGN_CHECK_EN
                    addr_err_r <= 1'b0;
`endif
                end
                default: begin
                    state_r <= IDLE;
                    ack_r   <= 1'b0;
                    busy_r  <= 1'b0;
                    rd_r    <= 1'b0;
                    wr_r    <= 1'b0;
                end
            endcase
        end
    end

    assign ack    = ack_r;
    assign busy   = busy_r;
    assign rdata  = rdata_r;
    assign Addr   = ram_addr_r;
    assign R      = rd_r;
    assign W      = wr_r;
    assign W_data = ram_wdata_r;

endmodule

// File: tb/tb_mem_req_ctrl.sv
// Self-checking bench for mem_req_ctrl: a schedule-based reference model plus a
// word-wide RAM device, with directed load/store vectors and literal expectations.
module tb_mem_req_ctrl;

    localparam int RD_LAT = 2;
    localparam int NE     = 4096;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req = 1'b0;
    logic        we = 1'b0;
    logic [1:0]  size = 2'b10;
    logic        sign_ext = 1'b0;
    logic [31:0] addr = 32'h0;
    logic [31:0] wdata = 32'h0;
    logic        ack, busy, addr_err, R, W;
    logic [31:0] rdata, Addr, W_data;
    logic [31:0] R_data = 32'h0;

    int checks = 0;
    int errors = 0;

    mem_req_ctrl #(.RD_LAT(RD_LAT), .AW(32)) dut (
        .clk(clk), .rst(rst), .req(req), .we(we), .size(size), .sign_ext(sign_ext),
        .addr(addr), .wdata(wdata), .ack(ack), .rdata(rdata), .busy(busy),
        .addr_err(addr_err), .Addr(Addr), .R(R), .W(W), .W_data(W_data), .R_data(R_data)
    );

    always #5 clk = ~clk;

    // Device RAM and model RAM
    logic [31:0] dev_mem   [0:255];
    logic [31:0] model_mem [0:255];
    int r_run = 0;

    // Expected outputs, indexed by the edge after which they are visible
    bit        exp_ack  [NE];
    bit        exp_busy [NE];
    bit        exp_r    [NE];
    bit        exp_w    [NE];
    bit        exp_err  [NE];
    bit [31:0] exp_adr  [NE];
    bit [31:0] exp_wd   [NE];
    int        e_cnt = 0;
    int        free_edge = 0;
    bit        pend_valid = 1'b0;
    int        pend_edge = 0;
    logic [31:0] pend_val = 32'h0;
    logic [31:0] model_rdata = 32'h0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at edge %0d: got %h expected %h", nm, e_cnt, act, exp);
        end
    endtask

    function automatic logic [31:0] m_load(input logic [31:0] w, input logic [1:0] lo,
                                           input logic [1:0] sz, input logic sx);
        logic [31:0] v;
        int sh;
        if (sz == 2'b00) begin
            sh = 8 * int'(lo);
            v = (w >> sh) & 32'h0000_00FF;
            if (sx && v[7]) v = v | 32'hFFFF_FF00;
        end else if (sz == 2'b01) begin
            sh = 16 * int'(lo[1]);
            v = (w >> sh) & 32'h0000_FFFF;
            if (sx && v[15]) v = v | 32'hFFFF_0000;
        end else begin
            v = w;
        end
        return v;
    endfunction

    function automatic logic [31:0] m_merge(input logic [31:0] w, input logic [1:0] lo,
                                            input logic [1:0] sz, input logic [31:0] wd);
        logic [31:0] mask;
        int sh;
        if (sz == 2'b00) begin
            sh = 8 * int'(lo);
            mask = 32'h0000_00FF << sh;
        end else begin
            sh = 16 * int'(lo[1]);
            mask = 32'h0000_FFFF << sh;
        end
        return (w & ~mask) | ((wd << sh) & mask);
    endfunction

    task automatic model_accept(input int e0);
        int idx;
        logic [31:0] res;
        logic [31:0] wa;
        idx = int'(addr[9:2]);
        wa = {addr[31:2], 2'b00};
`ifdef MEM_ALIGN_CHECK_EN
        if ((size == 2'b01 && addr[0]) || (size[1] && addr[1:0] != 2'b00)) begin
            exp_ack[e0] = 1'b1;
            exp_err[e0] = 1'b1;
            free_edge = e0 + 2;
            return;
        end
`endif
        if (we && size[1]) begin
            exp_w[e0] = 1'b1; exp_wd[e0] = wdata; exp_adr[e0] = wa; exp_busy[e0] = 1'b1;
            exp_ack[e0 + 1] = 1'b1;
            model_mem[idx] = wdata;
            free_edge = e0 + 3;
        end else begin
            for (int k = 0; k < RD_LAT; k++) begin
                exp_r[e0 + k] = 1'b1; exp_busy[e0 + k] = 1'b1; exp_adr[e0 + k] = wa;
            end
            if (!we) begin
                exp_ack[e0 + RD_LAT] = 1'b1;
                pend_val = m_load(model_mem[idx], addr[1:0], size, sign_ext);
                pend_edge = e0 + RD_LAT;
                pend_valid = 1'b1;
                free_edge = e0 + RD_LAT + 2;
            end else begin
                res = m_merge(model_mem[idx], addr[1:0], size, wdata);
                model_mem[idx] = res;
                exp_w[e0 + RD_LAT] = 1'b1; exp_wd[e0 + RD_LAT] = res;
                exp_adr[e0 + RD_LAT] = wa; exp_busy[e0 + RD_LAT] = 1'b1;
                exp_ack[e0 + RD_LAT + 1] = 1'b1;
                free_edge = e0 + RD_LAT + 3;
            end
        end
    endtask

    // Model: advances one edge per rising clock, reading only the DUT inputs
    initial begin
        forever begin
            @(posedge clk);
            e_cnt = e_cnt + 1;
            if (rst) begin
                for (int i = e_cnt; i < e_cnt + 32; i++) begin
                    exp_ack[i] = 1'b0; exp_busy[i] = 1'b0; exp_r[i] = 1'b0;
                    exp_w[i] = 1'b0; exp_err[i] = 1'b0; exp_adr[i] = 32'h0; exp_wd[i] = 32'h0;
                end
                pend_valid = 1'b0;
                model_rdata = 32'h0;
                free_edge = e_cnt + 1;
            end else begin
                if (pend_valid && e_cnt == pend_edge) begin
                    model_rdata = pend_val;
                    pend_valid = 1'b0;
                end
                if (req && e_cnt >= free_edge) model_accept(e_cnt);
            end
        end
    end

    // Device RAM: write on W, return data only once R has been held RD_LAT cycles
    initial begin
        forever begin
            @(negedge clk);
            if (W === 1'b1) dev_mem[Addr[9:2]] = W_data;
            r_run = (R === 1'b1) ? r_run + 1 : 0;
            R_data = (R === 1'b1 && r_run >= RD_LAT) ? dev_mem[Addr[9:2]] : 32'hBAD0_BAD0;
        end
    end

    // Per-cycle comparison against the model
    initial begin
        forever begin
            @(negedge clk);
            if (e_cnt >= 1 && e_cnt < NE - 40) begin
                chk("ack", {31'h0, ack}, {31'h0, exp_ack[e_cnt]});
                chk("busy", {31'h0, busy}, {31'h0, exp_busy[e_cnt]});
                chk("R", {31'h0, R}, {31'h0, exp_r[e_cnt]});
                chk("W", {31'h0, W}, {31'h0, exp_w[e_cnt]});
                chk("addr_err", {31'h0, addr_err}, {31'h0, exp_err[e_cnt]});
                chk("rdata", rdata, model_rdata);
                chk("R_and_W", {31'h0, R & W}, 32'h0);
                if (exp_r[e_cnt] || exp_w[e_cnt]) chk("Addr", Addr, exp_adr[e_cnt]);
                if (exp_w[e_cnt]) chk("W_data", W_data, exp_wd[e_cnt]);
            end
        end
    end

    task automatic poke(input logic [31:0] a, input logic [31:0] v);
        dev_mem[a[9:2]] = v;
        model_mem[a[9:2]] = v;
    endtask

    // mode 0: one-cycle req, 1: req held until ack, 2: extra req pulse during RD
    task automatic do_req(input logic we_i, input logic [1:0] sz, input logic sx,
                          input logic [31:0] a, input logic [31:0] wd, input int mode,
                          output int lat);
        we = we_i; size = sz; sign_ext = sx; addr = a; wdata = wd; req = 1'b1;
        lat = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (ack === 1'b1) lat = i;
            case (mode)
                1:       req = (ack === 1'b1) ? 1'b0 : 1'b1;
                2:       req = (i == 2) ? 1'b1 : 1'b0;
                default: req = 1'b0;
            endcase
            if (lat != 0) break;
        end
        req = 1'b0;
        if (lat == 0) begin
            checks++;
            errors++;
            $display("FAIL ack_timeout for addr %h: no ack within 20 cycles", a);
        end
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int acks;
        for (int i = 0; i < 256; i++) begin
            dev_mem[i] = 32'h0;
            model_mem[i] = 32'h0;
        end
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_ack", {31'h0, ack}, 32'h0);
        chk("rst_busy", {31'h0, busy}, 32'h0);
        chk("rst_RW", {30'h0, R, W}, 32'h0);
        chk("rst_Addr", Addr, 32'h0);
        chk("rst_W_data", W_data, 32'h0);
        chk("rst_rdata", rdata, 32'h0);
        chk("rst_addr_err", {31'h0, addr_err}, 32'h0);
        @(negedge clk);

        // Word store then load
        do_req(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEAD_BEEF, 0, lat);
        chk("lat_sw", lat, 32'd2);
        do_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 0, lat);
        chk("lat_lw", lat, RD_LAT + 1);
        chk("lw_10", rdata, 32'hDEAD_BEEF);

        // Byte and half loads with both extensions
        poke(32'h20, 32'h80FF_7F01);
        do_req(1'b0, 2'b00, 1'b1, 32'h23, 32'h0, 0, lat);
        chk("lb_23", rdata, 32'hFFFF_FF80);
        do_req(1'b0, 2'b00, 1'b0, 32'h23, 32'h0, 0, lat);
        chk("lbu_23", rdata, 32'h0000_0080);
        do_req(1'b0, 2'b00, 1'b1, 32'h21, 32'h0, 0, lat);
        chk("lb_21", rdata, 32'h0000_007F);
        do_req(1'b0, 2'b01, 1'b1, 32'h22, 32'h0, 0, lat);
        chk("lh_22", rdata, 32'hFFFF_80FF);
        do_req(1'b0, 2'b01, 1'b0, 32'h20, 32'h0, 0, lat);
        chk("lhu_20", rdata, 32'h0000_7F01);

        // Sub-word stores via read-modify-write
        poke(32'h30, 32'h1122_3344);
        do_req(1'b1, 2'b01, 1'b0, 32'h32, 32'h5555_ABCD, 0, lat);
        chk("lat_sh", lat, RD_LAT + 2);
        chk("rdata_kept_on_store", rdata, 32'h0000_7F01);
        do_req(1'b0, 2'b10, 1'b0, 32'h30, 32'h0, 0, lat);
        chk("lw_30_after_sh", rdata, 32'hABCD_3344);
        do_req(1'b1, 2'b00, 1'b0, 32'h31, 32'h7777_775A, 0, lat);
        do_req(1'b0, 2'b11, 1'b0, 32'h30, 32'h0, 0, lat);
        chk("lw_30_after_sb", rdata, 32'hABCD_5A44);
        do_req(1'b0, 2'b10, 1'b0, 32'h12, 32'h0, 0, lat);
        chk("lw_low_bits_ignored", rdata, 32'hDEAD_BEEF);

        // Handshake: held req gives one ack, extra pulse during RD is ignored
        do_req(1'b0, 2'b01, 1'b0, 32'h32, 32'h0, 1, lat);
        chk("lat_hold", lat, RD_LAT + 1);
        chk("lhu_32_hold", rdata, 32'h0000_ABCD);
        acks = 0;
        repeat (3) begin
            @(negedge clk);
            if (ack === 1'b1) acks++;
        end
        chk("hold_single_ack", acks, 32'd0);
        do_req(1'b0, 2'b00, 1'b0, 32'h20, 32'h0, 2, lat);
        chk("lbu_20_repulse", rdata, 32'h0000_0001);
        acks = 0;
        repeat (4) begin
            @(negedge clk);
            if (ack === 1'b1) acks++;
        end
        chk("repulse_no_second_ack", acks, 32'd0);

        // Reset asserted during RD aborts the load
        we = 1'b0; size = 2'b10; addr = 32'h20; req = 1'b1;
        @(negedge clk);
        req = 1'b0;
        chk("mid_rd_R", {31'h0, R}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        #1;
        chk("abort_R", {31'h0, R}, 32'h0);
        chk("abort_busy", {31'h0, busy}, 32'h0);
        chk("abort_ack", {31'h0, ack}, 32'h0);
        chk("abort_rdata", rdata, 32'h0);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        do_req(1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 0, lat);
        chk("lw_after_abort", rdata, 32'h80FF_7F01);

`ifdef MEM_ALIGN_CHECK_EN
        // Misaligned word load is trapped without touching the RAM
        we = 1'b0; size = 2'b10; addr = 32'h41; req = 1'b1;
        @(negedge clk);
        req = 1'b0;
        chk("misalign_ack", {31'h0, ack}, 32'd1);
        chk("misalign_err", {31'h0, addr_err}, 32'd1);
        chk("misalign_RW", {30'h0, R, W}, 32'h0);
        chk("misalign_rdata", rdata, 32'h80FF_7F01);
        repeat (2) @(negedge clk);
`endif

        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
